// File: rtl/key_filter_if.sv
// key_filter bus: raw button inputs and the filtered outputs.
// master = filter side, slave = consumer/driver side.
interface key_filter_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] keyin;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;

  modport master (
    input  keyin,
    output key_level,
    output key_press,
    output key_release
  );

  modport slave (
    output keyin,
    input  key_level,
    input  key_press,
    input  key_release
  );
endinterface

// File: rtl/key_filter.sv
// Per-key synchroniser, debouncer and edge/auto-repeat pulser.
// Each key owns a 4-state FSM; all outputs are registered.
module key_filter #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 100000,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic         clk,
  input  logic         rstn,
  key_filter_if.master bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                           REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX + 1);
  localparam int RD_M1 = (REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0;
  localparam int RP_M1 = (REPEAT_PERIOD > 1) ? REPEAT_PERIOD - 1 : 0;

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES);
  localparam logic [RW-1:0] RD_LAST = RW'(RD_M1);
  localparam logic [RW-1:0] RP_LAST = RW'(RP_M1);
  localparam bit RPT_EN = (REPEAT_DELAY != 0);
  localparam bit ACT_LOW = (KEY_ACTIVE_LOW != 0);
  localparam logic IDLE_RAW = ACT_LOW ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } state_e;

  logic [NUM_KEYS-1:0] s1_q;
  logic [NUM_KEYS-1:0] s2_q;
  logic [NUM_KEYS-1:0] p;

  state_e        st_q  [NUM_KEYS];
  state_e        st_d  [NUM_KEYS];
  logic [DW-1:0] cnt_q [NUM_KEYS];
  logic [DW-1:0] cnt_d [NUM_KEYS];
  logic [RW-1:0] rpt_q [NUM_KEYS];
  logic [RW-1:0] rpt_d [NUM_KEYS];

  logic [NUM_KEYS-1:0] armed_q, armed_d;
  logic [NUM_KEYS-1:0] level_q, level_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] rel_q, rel_d;

  // Two-flop synchroniser; reset parks it at the released raw level.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_q <= {NUM_KEYS{IDLE_RAW}};
      s2_q <= {NUM_KEYS{IDLE_RAW}};
    end else begin
      s1_q <= bus.keyin;
      s2_q <= s1_q;
    end
  end

  assign p = ACT_LOW ? ~s2_q : s2_q;

  // Next-state logic for every key's debounce / repeat FSM.
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      st_d[i]    = st_q[i];
      cnt_d[i]   = cnt_q[i];
      rpt_d[i]   = rpt_q[i];
      armed_d[i] = armed_q[i];
      level_d[i] = level_q[i];
      press_d[i] = 1'b0;
      rel_d[i]   = 1'b0;
      unique case (st_q[i])
        IDLE: begin
          if (p[i]) begin
            st_d[i]  = PRESS_DB;
            cnt_d[i] = DW'(1);
          end
        end
        PRESS_DB: begin
          if (!p[i]) begin
            st_d[i]  = IDLE;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == DB_LAST) begin
            st_d[i]    = HELD;
            cnt_d[i]   = '0;
            rpt_d[i]   = '0;
            armed_d[i] = 1'b0;
            press_d[i] = 1'b1;
            level_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + DW'(1);
          end
        end
        HELD: begin
          if (!p[i]) begin
            st_d[i]  = RELEASE_DB;
            cnt_d[i] = DW'(1);
          end else if (RPT_EN) begin
            if (armed_q[i] ? (rpt_q[i] == RP_LAST)
                           : (rpt_q[i] == RD_LAST)) begin
              press_d[i] = 1'b1;
              rpt_d[i]   = '0;
              armed_d[i] = 1'b1;
            end else begin
              rpt_d[i] = rpt_q[i] + RW'(1);
            end
          end
        end
        RELEASE_DB: begin
          if (p[i]) begin
            st_d[i]    = HELD;
            cnt_d[i]   = '0;
            rpt_d[i]   = '0;
            armed_d[i] = 1'b0;
          end else if (cnt_q[i] == DB_LAST) begin
            st_d[i]    = IDLE;
            cnt_d[i]   = '0;
            rel_d[i]   = 1'b1;
            level_d[i] = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] + DW'(1);
          end
        end
      endcase
    end
  end

  // State, counter and output registers; reset drops everything silently.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        st_q[i]  <= IDLE;
        cnt_q[i] <= '0;
        rpt_q[i] <= '0;
      end
      armed_q <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
        rpt_q[i] <= rpt_d[i];
      end
      armed_q <= armed_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign bus.key_level   = level_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = rel_q;

endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter: directed scenarios plus random keys/resets
// checked against a run-length reference model, two repeat settings.
module tb_key_filter;

  localparam int NK = 4;
  localparam int DB = 8;
  localparam int RP = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [NK-1:0] keyin = '1;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  key_filter_if #(.NUM_KEYS(NK)) ifa ();
  key_filter_if #(.NUM_KEYS(NK)) ifb ();

  assign ifa.keyin = keyin;
  assign ifb.keyin = keyin;

  key_filter #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(0),
    .REPEAT_PERIOD(RP), .KEY_ACTIVE_LOW(1)
  ) dut_a (.clk(clk), .rstn(rstn), .bus(ifa.master));

  key_filter #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(32),
    .REPEAT_PERIOD(RP), .KEY_ACTIVE_LOW(1)
  ) dut_b (.clk(clk), .rstn(rstn), .bus(ifb.master));

  // reference model state, index [dut][key]
  int m_rd [2] = '{0, 32};
  int m_lvl [2][NK];
  int m_run [2][NK];
  int m_ht  [2][NK];
  bit m_p1  [2][NK];
  bit m_p2  [2][NK];
  logic [NK-1:0] e_lvl [2];
  logic [NK-1:0] e_prs [2];
  logic [NK-1:0] e_rel [2];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accepted level flips once the synced input has disagreed with it
  // on DB+1 consecutive edges; repeats count edges since HELD entry.
  task automatic model_step(logic r, logic [NK-1:0] kin);
    for (int d = 0; d < 2; d++) begin
      e_prs[d] = '0;
      e_rel[d] = '0;
      for (int k = 0; k < NK; k++) begin
        if (!r) begin
          m_lvl[d][k] = 0; m_run[d][k] = 0; m_ht[d][k] = 0;
          m_p1[d][k] = 0;  m_p2[d][k] = 0;
        end else begin
          bit pv;
          pv = m_p2[d][k];
          m_p2[d][k] = m_p1[d][k];
          m_p1[d][k] = ~kin[k];
          if (int'(pv) != m_lvl[d][k]) begin
            m_run[d][k]++;
            if (m_run[d][k] == DB + 1) begin
              m_run[d][k] = 0;
              m_lvl[d][k] = 1 - m_lvl[d][k];
              m_ht[d][k] = 0;
              if (m_lvl[d][k] == 1) e_prs[d][k] = 1'b1;
              else e_rel[d][k] = 1'b1;
            end
          end else if (m_lvl[d][k] == 1) begin
            if (m_run[d][k] > 0) begin
              m_run[d][k] = 0;
              m_ht[d][k] = 0;
            end else if (m_rd[d] != 0) begin
              m_ht[d][k]++;
              if (m_ht[d][k] == m_rd[d] ||
                  (m_ht[d][k] > m_rd[d] &&
                   (m_ht[d][k] - m_rd[d]) % RP == 0))
                e_prs[d][k] = 1'b1;
            end
          end else begin
            m_run[d][k] = 0;
          end
        end
        e_lvl[d][k] = (m_lvl[d][k] == 1);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rstn, keyin);
    #1;
    check("a_level",   32'(ifa.key_level),   32'(e_lvl[0]));
    check("a_press",   32'(ifa.key_press),   32'(e_prs[0]));
    check("a_release", 32'(ifa.key_release), 32'(e_rel[0]));
    check("b_level",   32'(ifb.key_level),   32'(e_lvl[1]));
    check("b_press",   32'(ifb.key_press),   32'(e_prs[1]));
    check("b_release", 32'(ifb.key_release), 32'(e_rel[1]));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int first;
    int hits;
    int q_prs[$];
    int q_rel[$];
    int exp_rep[5] = '{10, 42, 58, 74, 90};

    // 1: reset with all keys held, then all four debounce together
    rstn = 1'b0;
    keyin = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s1_rst_out",
            32'({ifa.key_level, ifa.key_press, ifa.key_release}), 32'h0);
    end
    rstn = 1'b1;
    first = -1;
    hits = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (ifa.key_press == 4'hf) begin
        hits++;
        if (first < 0) first = c;
      end
      if (c >= 10)
        check("s1_level_hold", 32'(ifa.key_level), 32'hf);
    end
    check("s1_press_cycle", 32'(first), 32'd10);
    check("s1_press_count", 32'(hits), 32'd1);
    keyin = 4'b1111;
    idle(20);

    // 2: two short bounces on key 0
    hits = 0;
    keyin[0] = 1'b0; idle(5);
    keyin[0] = 1'b1; idle(3);
    keyin[0] = 1'b0; idle(5);
    keyin[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      hits += int'(ifa.key_level[0] | ifa.key_press[0]);
      hits += int'(ifa.key_release[0]);
    end
    check("s2_no_activity", 32'(hits), 32'd0);
    idle(10);

    // 3: auto-repeat on key 2 with the delayed-repeat instance
    keyin[2] = 1'b0;
    for (int c = 0; c < 140; c++) begin
      if (c == 100) keyin[2] = 1'b1;
      tick();
      if (ifb.key_press[2]) q_prs.push_back(c);
      if (ifb.key_release[2]) q_rel.push_back(c);
    end
    check("s3_press_count", 32'(q_prs.size()), 32'd5);
    for (int i = 0; i < 5 && i < q_prs.size(); i++)
      check("s3_press_at", 32'(q_prs[i]), 32'(exp_rep[i]));
    check("s3_rel_count", 32'(q_rel.size()), 32'd1);
    if (q_rel.size() > 0)
      check("s3_rel_at", 32'(q_rel[0]), 32'd110);

    // 4: key 1 bounces high briefly while held
    keyin[1] = 1'b0;
    first = -1;
    for (int c = 0; c < 30 && first < 0; c++) begin
      tick();
      if (ifa.key_level[1]) first = c;
    end
    check("s4_level_seen", 32'(first >= 0), 32'd1);
    hits = 0;
    keyin[1] = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (c == 4) keyin[1] = 1'b0;
      tick();
      hits += int'(ifa.key_press[1]) + int'(ifa.key_release[1]);
      hits += int'(!ifa.key_level[1]);
    end
    check("s4_no_glitch", 32'(hits), 32'd0);
    keyin[1] = 1'b1;
    idle(20);

    // 5: reset while key 3 is held, then it re-debounces
    keyin[3] = 1'b0;
    first = -1;
    for (int c = 0; c < 30 && first < 0; c++) begin
      tick();
      if (ifa.key_level[3]) first = c;
    end
    check("s5_level_seen", 32'(first >= 0), 32'd1);
    rstn = 1'b0;
    tick();
    check("s5_rst_out",
          32'({ifa.key_level, ifa.key_press, ifa.key_release}), 32'h0);
    rstn = 1'b1;
    first = -1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ifa.key_press[3] && first < 0) first = c;
    end
    check("s5_press_cycle", 32'(first), 32'd10);
    keyin = '1;
    idle(20);

    // random keys, bounce lengths around the debounce window, resets
    for (int seg = 0; seg < 400; seg++) begin
      int len;
      if ($urandom_range(0, 3) == 0) keyin = NK'($urandom);
      else keyin[$urandom_range(0, NK - 1)] ^= 1'b1;
      rstn = ($urandom_range(0, 59) != 0);
      len = ($urandom_range(0, 4) == 0) ?
            $urandom_range(20, 80) : $urandom_range(1, 14);
      tick();
      rstn = 1'b1;
      idle(len - 1);
    end
    keyin = '1;
    idle(30);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
